// File: rtl/irs_trigger_block_locker.sv
// Records acknowledged block addresses in a circular history and, on trigger, locks a
// pre/post window one block at a time, queueing each locked address in a FWFT FIFO.
module irs_trigger_block_locker #(
  parameter int HIST_AW = 5,
  parameter int FIFO_AW = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [8:0] blk_i,
  input  logic       blk_ack_i,
  input  logic       trig_i,
  input  logic [3:0] pre_blocks_i,
  input  logic [3:0] post_blocks_i,
  output logic [8:0] lock_address_o,
  output logic       lock_o,
  output logic       lock_strobe_o,
  input  logic       lock_ack_i,
  output logic [8:0] rd_blk_o,
  output logic       rd_valid_o,
  input  logic       rd_ready_i,
  output logic       busy_o,
  output logic       event_done_o,
  output logic       overrun_o,
  output logic       trig_dropped_o
);

  localparam int HD = 1 << HIST_AW;
  localparam int FD = 1 << FIFO_AW;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOCK, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [8:0]           hist_mem [HD];
  logic [HIST_AW-1:0]   wptr_q, rptr_q, rptr_d, hist_cnt_q;
  logic [4:0]           remaining_q, remaining_d;
  logic [8:0]           lock_addr_q, lock_addr_d;
  logic                 overrun_q, overrun_d;
  logic                 abort_q, abort_d;
  logic                 trig_drop_q, trig_drop_d;

  logic [8:0]           fifo_mem [FD];
  logic [FIFO_AW-1:0]   fwr_q, frd_q;
  logic [FIFO_AW:0]     fcnt_q;

  logic [HIST_AW-1:0]   wptr_eff, hc_eff, pre_ext, npre, pending;
  logic                 ovr_hit, fifo_full, fifo_empty, fifo_push, fifo_pop;

  // A block acked in the trigger cycle counts as pre-trigger history.
  assign wptr_eff = blk_ack_i ? wptr_q + HIST_AW'(1) : wptr_q;
  assign hc_eff   = (blk_ack_i && (hist_cnt_q != '1)) ? hist_cnt_q + HIST_AW'(1) : hist_cnt_q;
  assign pre_ext  = HIST_AW'(pre_blocks_i);
  assign npre     = (pre_ext < hc_eff) ? pre_ext : hc_eff;
  assign pending  = wptr_q - rptr_q;
  assign ovr_hit  = blk_ack_i && (pending == '1);

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == (FIFO_AW+1)'(FD));
  assign fifo_pop   = rd_ready_i && !fifo_empty;
  assign fifo_push  = (state_q == S_LOCK) && lock_ack_i && (!fifo_full || fifo_pop);

  always_comb begin
    state_d     = state_q;
    rptr_d      = rptr_q;
    remaining_d = remaining_q;
    lock_addr_d = lock_addr_q;
    overrun_d   = overrun_q;
    abort_d     = abort_q;
    trig_drop_d = trig_i && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (trig_i) begin
          rptr_d      = wptr_eff - npre;
          remaining_d = 5'(npre) + 5'(post_blocks_i);
          overrun_d   = 1'b0;
          state_d     = (5'(npre) + 5'(post_blocks_i) == 5'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (ovr_hit) begin
          overrun_d = 1'b1;
          state_d   = S_DONE;
        end else if ((rptr_q != wptr_q) && !fifo_full) begin
          lock_addr_d = hist_mem[rptr_q];
          state_d     = S_LOCK;
        end
      end
      S_LOCK: begin
        // An overrun during a lock lets the in-flight lock finish before aborting.
        if (ovr_hit) begin
          overrun_d = 1'b1;
          abort_d   = 1'b1;
        end
        if (lock_ack_i) begin
          rptr_d      = rptr_q + HIST_AW'(1);
          remaining_d = remaining_q - 5'd1;
          state_d     = ((remaining_q == 5'd1) || abort_q || ovr_hit) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      hist_cnt_q  <= '0;
      remaining_q <= '0;
      lock_addr_q <= '0;
      overrun_q   <= 1'b0;
      abort_q     <= 1'b0;
      trig_drop_q <= 1'b0;
      fwr_q       <= '0;
      frd_q       <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rptr_q      <= rptr_d;
      remaining_q <= remaining_d;
      lock_addr_q <= lock_addr_d;
      overrun_q   <= overrun_d;
      abort_q     <= abort_d;
      trig_drop_q <= trig_drop_d;
      if (blk_ack_i) begin
        wptr_q <= wptr_q + HIST_AW'(1);
        if (hist_cnt_q != '1) hist_cnt_q <= hist_cnt_q + HIST_AW'(1);
      end
      if (fifo_push) fwr_q <= fwr_q + FIFO_AW'(1);
      if (fifo_pop)  frd_q <= frd_q + FIFO_AW'(1);
      fcnt_q <= fcnt_q + (FIFO_AW+1)'(fifo_push) - (FIFO_AW+1)'(fifo_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (blk_ack_i) hist_mem[wptr_q] <= blk_i;
    if (fifo_push) fifo_mem[fwr_q]  <= lock_addr_q;
  end

  assign lock_address_o = lock_addr_q;
  assign lock_o         = 1'b1;
  assign lock_strobe_o  = (state_q == S_LOCK);
  assign rd_valid_o     = !fifo_empty;
  assign rd_blk_o       = fifo_empty ? 9'd0 : fifo_mem[frd_q];
  assign busy_o         = (state_q != S_IDLE);
  assign event_done_o   = (state_q == S_DONE);
  assign overrun_o      = overrun_q;
  assign trig_dropped_o = trig_drop_q;

endmodule
